// File: rtl/apb_master.sv
// APB requester: turns a single cmd valid/ready request into one APB transfer
// and returns the result on a rsp valid/ready channel, aborting on PREADY timeout.
module apb_master #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TMO_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;

    // Next-state and datapath; handshake outputs are pre-decoded from state_d
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wait_d   = wait_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                    if (TMO_EN && (wait_q == CNT_LAST)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles with PREADY low before abort; 0 disables the timeout.
REQ-004 SHALL have port clk  in  1  single clock; all state is on the rising edge.
REQ-005 SHALL have port PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  in  ADDR_W  transfer address.
REQ-010 SHALL have port cmd_wdata  in  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  response consumed.
REQ-013 SHALL have port rsp_rdata  out  DATA_W  read data; 0 for writes and on error.
REQ-014 SHALL have port rsp_err  out  1  transfer aborted by timeout.
REQ-015 SHALL have ports PSEL, PENABLE and PWRITE, each out 1, as APB requester controls.
REQ-016 SHALL have ports PADDR (out, ADDR_W) and PWDATA (out, DATA_W), the APB address and write-data buses.
REQ-017 SHALL have ports PRDATA (in, DATA_W) and PREADY (in, 1), the completer read data and ready.

Function
REQ-018 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; cmd_* inputs SHALL be ignored otherwise.
REQ-020 In IDLE, cmd_valid=1 at a clock edge SHALL latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and go to SETUP.
REQ-021 In SETUP, PSEL=1 and PENABLE=0 for exactly one cycle, then the FSM SHALL go to ACCESS.
REQ-022 In ACCESS, PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA SHALL remain stable.
REQ-023 In ACCESS, PREADY=1 at an edge SHALL register rsp_rdata=PRDATA (reads) or 0 (writes) and rsp_err=0, then go to RESP.
REQ-024 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-025 When TIMEOUT>0 and the TIMEOUT-th consecutive PREADY=0 edge occurs, the FSM SHALL register rsp_err=1 and rsp_rdata=0, then go to RESP.
REQ-026 In RESP, rsp_valid=1, PSEL=0 and PENABLE=0; rsp_rdata and rsp_err SHALL be held until rsp_ready=1 at an edge, then the FSM SHALL go to IDLE.
REQ-027 PSEL, PENABLE and rsp_valid SHALL be 0 in IDLE.
REQ-028 PADDR, PWRITE and PWDATA SHALL retain their last values outside SETUP and ACCESS until the next command is accepted.
REQ-029 PREADY and PRDATA SHALL be ignored outside ACCESS.
REQ-030 Minimum transfer period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP); there is no command pipelining.
REQ-031 All outputs SHALL be registered or decoded from registered state only; cmd_ready SHALL NOT depend combinationally on any input.

Reset
REQ-032 PRESETn=0 SHALL immediately force state IDLE and set PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter to 0.
REQ-033 An in-flight transfer interrupted by reset SHALL be dropped with no response.
REQ-034 cmd_ready SHALL read 1 from the first edge after PRESETn deasserts.

Verification
REQ-035 Write to 0x3 with data 0xDEADBEEF, PREADY tied 1 -> PSEL rises the cycle after accept, PENABLE one cycle later, rsp_valid one cycle after that with rsp_err=0 and rsp_rdata=0; PWRITE=1 throughout.
REQ-036 Read from 0x5, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> ACCESS lasts 4 cycles, then rsp_rdata=0x12345678 and rsp_err=0.
REQ-037 TIMEOUT=16, PREADY held 0 -> after 16 ACCESS cycles PSEL and PENABLE drop, then rsp_valid=1, rsp_err=1 and rsp_rdata=0.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data are held and cmd_ready=0; a concurrent cmd_valid is not accepted until after the handshake.
REQ-039 PRESETn pulsed low during ACCESS -> PSEL, PENABLE and rsp_valid go to 0 without waiting for a clock edge, no response is issued, and cmd_ready=1 after release.
REQ-040 Two back-to-back commands with rsp_ready=1 and PREADY=1 -> the second PSEL rising edge occurs exactly 4 cycles after the first.
